// File: rtl/ram_bist_ctrl_if.sv
// RAM-side bus between the BIST controller and the 8x8 single-port RAM.
// The controller drives address/data/write; the RAM returns registered read data.
interface ram_bist_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output mem_adr,
    output mem_data_in,
    output mem_write,
    input  mem_data_out
  );

  modport slave (
    input  mem_adr,
    input  mem_data_in,
    input  mem_write,
    output mem_data_out
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
// Two-round RAM self-test: write seed+a, read back and compare, then repeat with the
// inverted pattern. Reports pass, mismatch count and the first failing address.
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_WRITE | writing pattern to address a, one location per cycle
// S_READ  | issuing read of address a, one location per cycle
// S_DRAIN | two idle cycles so the last read compare completes
// S_DONE  | result held until the next start
module ram_bist_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  ram_bist_ctrl_if.master     mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W+1:0]   fail_cnt,
  output logic [ADDR_W-1:0]   first_fail_adr
);

  localparam logic [ADDR_W-1:0] LAST_ADR = '1;
  localparam logic [ADDR_W+1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   a, a_nxt;
  logic                r, r_nxt;
  logic [DATA_W-1:0]   seed_q, seed_nxt;
  logic                mem_write_q, mem_write_nxt;
  logic [DATA_W-1:0]   data_in_q, data_in_nxt;
  logic                busy_nxt, done_nxt, pass_nxt;
  logic [ADDR_W+1:0]   fail_cnt_nxt;
  logic [ADDR_W-1:0]   ffa_nxt;
  logic                p_vld, p_vld_nxt;
  logic [ADDR_W-1:0]   p_adr, p_adr_nxt;
  logic [DATA_W-1:0]   p_exp, p_exp_nxt;
  logic                mismatch;

  function automatic logic [DATA_W-1:0] pat(
    input logic [DATA_W-1:0] base,
    input logic [ADDR_W-1:0] adr,
    input logic              inv
  );
    logic [DATA_W-1:0] sum;
    sum = base + DATA_W'(adr);
    return inv ? ~sum : sum;
  endfunction

  // a doubles as the registered RAM address, so mem_adr comes straight from a flop
  assign mem.mem_adr     = a;
  assign mem.mem_data_in = data_in_q;
  assign mem.mem_write   = mem_write_q;

  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    r_nxt         = r;
    seed_nxt      = seed_q;
    mem_write_nxt = 1'b0;
    data_in_nxt   = '0;
    busy_nxt      = busy;
    done_nxt      = done;
    pass_nxt      = pass;
    fail_cnt_nxt  = fail_cnt;
    ffa_nxt       = first_fail_adr;
    p_vld_nxt     = 1'b0;
    p_adr_nxt     = a;
    p_exp_nxt     = pat(seed_q, a, r);

    // p_* holds the read issued last cycle; the RAM has just registered its data
    mismatch = p_vld && (mem.mem_data_out != p_exp);
    if (mismatch) begin
      if (fail_cnt != CNT_MAX) fail_cnt_nxt = fail_cnt + 1'b1;
      if (fail_cnt == '0)      ffa_nxt      = p_adr;
    end

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt     = S_WRITE;
          seed_nxt      = seed;
          a_nxt         = '0;
          r_nxt         = 1'b0;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          fail_cnt_nxt  = '0;
          ffa_nxt       = '0;
          mem_write_nxt = 1'b1;
          data_in_nxt   = pat(seed, '0, 1'b0);
        end
      end
      S_WRITE: begin
        if (a == LAST_ADR) begin
          state_nxt = S_READ;
          a_nxt     = '0;
        end else begin
          a_nxt         = a + 1'b1;
          mem_write_nxt = 1'b1;
          data_in_nxt   = pat(seed_q, a + 1'b1, r);
        end
      end
      S_READ: begin
        p_vld_nxt = 1'b1;
        if (a == LAST_ADR) begin
          state_nxt = S_DRAIN;
          a_nxt     = '0;
        end else begin
          a_nxt = a + 1'b1;
        end
      end
      S_DRAIN: begin
        if (a == ADDR_W'(1)) begin
          a_nxt = '0;
          if (!r) begin
            state_nxt     = S_WRITE;
            r_nxt         = 1'b1;
            mem_write_nxt = 1'b1;
            data_in_nxt   = pat(seed_q, '0, 1'b1);
          end else begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (fail_cnt_nxt == '0);
          end
        end else begin
          a_nxt = a + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      a              <= '0;
      r              <= 1'b0;
      seed_q         <= '0;
      mem_write_q    <= 1'b0;
      data_in_q      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_cnt       <= '0;
      first_fail_adr <= '0;
      p_vld          <= 1'b0;
      p_adr          <= '0;
      p_exp          <= '0;
    end else begin
      state          <= state_nxt;
      a              <= a_nxt;
      r              <= r_nxt;
      seed_q         <= seed_nxt;
      mem_write_q    <= mem_write_nxt;
      data_in_q      <= data_in_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      fail_cnt       <= fail_cnt_nxt;
      first_fail_adr <= ffa_nxt;
      p_vld          <= p_vld_nxt;
      p_adr          <= p_adr_nxt;
      p_exp          <= p_exp_nxt;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM model with injectable faults, table of full test runs,
// plus hand sequences for reset, start-while-busy and restart from DONE.
module tb_ram_bist_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic       busy, done, pass;
  logic [4:0] fail_cnt;
  logic [2:0] first_fail_adr;

  int checks = 0;
  int errors = 0;

  ram_bist_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus();

  ram_bist_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .seed           (seed),
    .mem            (bus.master),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_cnt       (fail_cnt),
    .first_fail_adr (first_fail_adr)
  );

  always #5 clock = ~clock;

  // fault modes: 0 none, 1 bit0 stuck-0 at fadr, 2 bit0 stuck-1 at fadr, 3 all data inverted
  int         fmode = 0;
  logic [2:0] fadr  = 3'd0;
  logic [7:0] memo [8];

  function automatic logic [7:0] stored(input logic [7:0] d, input logic [2:0] adr);
    case (fmode)
      1:       return (adr == fadr) ? (d & 8'hFE) : d;
      2:       return (adr == fadr) ? (d | 8'h01) : d;
      3:       return ~d;
      default: return d;
    endcase
  endfunction

  always @(posedge clock) begin
    if (bus.mem_write) memo[bus.mem_adr] <= stored(bus.mem_data_in, bus.mem_adr);
    bus.mem_data_out <= memo[bus.mem_adr];
  end

  int         wn = 0;
  logic [7:0] wdat [32];
  logic [2:0] wadr [32];

  always @(posedge clock) begin
    if (start && !busy && !reset) wn <= 0;
    else if (bus.mem_write && wn < 32) begin
      wdat[wn] <= bus.mem_data_in;
      wadr[wn] <= bus.mem_adr;
      wn       <= wn + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch with start sampled at edge 0; n returns the edge after which done was seen
  task automatic run_test(input logic [7:0] s, input bit pulse, output int n);
    @(negedge clock);
    seed  = s;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (pulse && n == 9) start = 1'b1;
      if (pulse && n == 10) begin
        start = 1'b0;
        chk("busy_at_pulse", int'(busy), 1);
      end
      if (done) break;
    end
  endtask

  typedef struct {
    logic [7:0] seed;
    int         mode;
    logic [2:0] adr;
    logic [7:0] w0;
    logic [7:0] w1;
    int         fcnt;
    int         ffa;
    int         pass;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    logic [7:0] e;

    vecs[0] = '{8'h00, 0, 3'd0, 8'h00, 8'hFF, 0,  0, 1};
    vecs[1] = '{8'hFC, 0, 3'd0, 8'hFC, 8'h03, 0,  0, 1};
    vecs[2] = '{8'h00, 1, 3'd5, 8'h00, 8'hFF, 1,  5, 0};
    vecs[3] = '{8'h01, 1, 3'd0, 8'h01, 8'hFE, 1,  0, 0};
    vecs[4] = '{8'hFF, 1, 3'd3, 8'hFF, 8'h00, 1,  3, 0};
    vecs[5] = '{8'h00, 2, 3'd6, 8'h00, 8'hFF, 1,  6, 0};
    vecs[6] = '{8'h10, 3, 3'd0, 8'h10, 8'hEF, 16, 0, 0};

    // reset held with start high: everything stays quiet
    reset = 1'b1;
    start = 1'b1;
    seed  = 8'hAA;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",      int'(busy), 0);
    chk("rst_mem_write", int'(bus.mem_write), 0);
    chk("rst_done",      int'(done), 0);
    chk("rst_fail_cnt",  int'(fail_cnt), 0);
    chk("rst_mem_adr",   int'(bus.mem_adr), 0);
    chk("rst_data_in",   int'(bus.mem_data_in), 0);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fmode = vecs[i].mode;
      fadr  = vecs[i].adr;
      run_test(vecs[i].seed, 1'b0, n);
      chk($sformatf("v%0d_done_edge", i), n, 36);
      chk($sformatf("v%0d_busy", i),      int'(busy), 0);
      chk($sformatf("v%0d_pass", i),      int'(pass), vecs[i].pass);
      chk($sformatf("v%0d_fail_cnt", i),  int'(fail_cnt), vecs[i].fcnt);
      chk($sformatf("v%0d_first_fail", i), int'(first_fail_adr), vecs[i].ffa);
      errs = (wn == 16) ? 0 : 1;
      for (int k = 0; k < 16 && k < wn; k++) begin
        e = (k < 8) ? vecs[i].w0 + 8'(k) : vecs[i].w1 - 8'(k - 8);
        if (wdat[k] != e || wadr[k] != 3'(k % 8)) errs++;
      end
      chk($sformatf("v%0d_write_trace", i), errs, 0);
    end

    // start pulsed at edge 10 while busy must not disturb the run
    fmode = 0;
    run_test(8'h00, 1'b1, n);
    chk("pulse_done_edge", n, 36);
    chk("pulse_pass",      int'(pass), 1);

    // start held in DONE restarts on the next edge
    @(negedge clock);
    seed  = 8'h20;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("restart_done",      int'(done), 0);
    chk("restart_busy",      int'(busy), 1);
    chk("restart_mem_write", int'(bus.mem_write), 1);
    chk("restart_data_in",   int'(bus.mem_data_in), 8'h20);
    n = 0;
    while (n < 100 && !done) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("restart_done_edge", n, 36);
    chk("restart_pass",      int'(pass), 1);

    // asynchronous reset mid-cycle during WRITE
    @(negedge clock);
    seed  = 8'h00;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    chk("pre_reset_mem_write", int'(bus.mem_write), 1);
    chk("pre_reset_mem_adr",   int'(bus.mem_adr), 4);
    reset = 1'b1;
    #1;
    chk("midrst_mem_write", int'(bus.mem_write), 0);
    chk("midrst_busy",      int'(busy), 0);
    chk("midrst_mem_adr",   int'(bus.mem_adr), 0);
    chk("midrst_data_in",   int'(bus.mem_data_in), 0);
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("midrst_start_ignored", int'(busy), 0);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    run_test(8'h00, 1'b0, n);
    chk("after_rst_done_edge", n, 36);
    chk("after_rst_pass",      int'(pass), 1);
    chk("after_rst_fail_cnt",  int'(fail_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
